// File: rtl/mc_riscv_controller.sv
// Multi-cycle RV32I control unit: a state-decoded FSM that sequences fetch, decode,
// execute, memory and writeback over a shared datapath with a ready-handshaked memory port.
module mc_riscv_controller #(
  parameter int ALU_CTRL_W  = 4,
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter bit BRANCH_FULL = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            i_op,
  input  logic [2:0]            i_funct3,
  input  logic                  i_funct7_5,
  input  logic                  i_zero,
  input  logic                  i_lt,
  input  logic                  i_ltu,
  input  logic                  i_mem_ready,
  output logic                  o_pc_write,
  output logic                  o_ir_write,
  output logic                  o_adr_src,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_reg_write,
  output logic [1:0]            o_result_src,
  output logic [1:0]            o_alu_src_a,
  output logic [1:0]            o_alu_src_b,
  output logic [2:0]            o_imm_src,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_illegal,
  output logic [3:0]            o_state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t     state_q, state_d;
  logic       illegal_q;
  logic       mem_ready;
  logic       branch_legal, branch_taken;
  alu_t       alu_funct, alu_ctrl;
  logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;

  assign mem_ready = i_mem_ready || !MEM_WAIT_EN;

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    branch_legal = 1'b0;
    branch_taken = 1'b0;
    case (i_funct3)
      3'b000: begin branch_legal = 1'b1;        branch_taken = i_zero;  end
      3'b001: begin branch_legal = 1'b1;        branch_taken = !i_zero; end
      3'b100: begin branch_legal = BRANCH_FULL; branch_taken = i_lt;    end
      3'b101: begin branch_legal = BRANCH_FULL; branch_taken = !i_lt;   end
      3'b110: begin branch_legal = BRANCH_FULL; branch_taken = i_ltu;   end
      3'b111: begin branch_legal = BRANCH_FULL; branch_taken = !i_ltu;  end
      default: ;
    endcase
  end

  // SUB only exists for register-register ops; funct7_5 on I-type add is immediate bits.
  always_comb begin
    alu_funct = ALU_ADD;
    case (i_funct3)
      3'b000: alu_funct = (state_q == S_EXECR && i_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_funct = ALU_SLL;
      3'b010: alu_funct = ALU_SLT;
      3'b011: alu_funct = ALU_SLTU;
      3'b100: alu_funct = ALU_XOR;
      3'b101: alu_funct = i_funct7_5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_funct = ALU_OR;
      default: alu_funct = ALU_AND;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_B;
        state_d   = S_TRAP;
        case (i_op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = branch_legal ? S_BRANCH : S_TRAP;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default: ;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = i_op[5] ? IMM_S : IMM_I;
        state_d   = i_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_ctrl  = alu_funct;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_ctrl  = alu_funct;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_ctrl  = ALU_SUB;
        pc_write  = branch_taken;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_JAL;
      end
      S_UPPER: begin
        alu_src_a = i_op[5] ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // NOTE: outputs are gated by reset combinationally so an in-flight strobe dies the moment reset asserts.
  assign o_pc_write   = i_rst_n & pc_write;
  assign o_ir_write   = i_rst_n & ir_write;
  assign o_adr_src    = i_rst_n & adr_src;
  assign o_mem_read   = i_rst_n & mem_read;
  assign o_mem_write  = i_rst_n & mem_write;
  assign o_reg_write  = i_rst_n & reg_write;
  assign o_result_src = i_rst_n ? result_src : 2'b00;
  assign o_alu_src_a  = i_rst_n ? alu_src_a : 2'b00;
  assign o_alu_src_b  = i_rst_n ? alu_src_b : 2'b00;
  assign o_imm_src    = i_rst_n ? imm_src : 3'b000;
  assign o_alu_ctrl   = i_rst_n ? ALU_CTRL_W'(alu_ctrl) : '0;
  assign o_illegal    = illegal_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_mc_riscv_controller.sv
// Bench for mc_riscv_controller: instruction-level sequence model with randomized
// ready/flags, plus a second instance without wait states and with reduced branches.
module tb_mc_riscv_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f75, zf, lt, ltu, ready;

  logic       a_pc_write, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write;
  logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b;
  logic [2:0] a_imm_src;
  logic [3:0] a_alu;
  logic       a_illegal;
  logic [3:0] a_state;

  logic       b_pc_write, b_ir_write, b_adr_src, b_mem_read, b_mem_write, b_reg_write;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
  logic [2:0] b_imm_src;
  logic [4:0] b_alu;
  logic       b_illegal;
  logic [3:0] b_state;

  mc_riscv_controller dut_a (
    .i_clk(clk), .i_rst_n(rst_n_a), .i_op(op), .i_funct3(f3), .i_funct7_5(f75),
    .i_zero(zf), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(ready),
    .o_pc_write(a_pc_write), .o_ir_write(a_ir_write), .o_adr_src(a_adr_src),
    .o_mem_read(a_mem_read), .o_mem_write(a_mem_write), .o_reg_write(a_reg_write),
    .o_result_src(a_result_src), .o_alu_src_a(a_alu_src_a), .o_alu_src_b(a_alu_src_b),
    .o_imm_src(a_imm_src), .o_alu_ctrl(a_alu), .o_illegal(a_illegal), .o_state(a_state)
  );

  mc_riscv_controller #(.ALU_CTRL_W(5), .MEM_WAIT_EN(1'b0), .BRANCH_FULL(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n_b), .i_op(op), .i_funct3(f3), .i_funct7_5(f75),
    .i_zero(zf), .i_lt(lt), .i_ltu(ltu), .i_mem_ready(ready),
    .o_pc_write(b_pc_write), .o_ir_write(b_ir_write), .o_adr_src(b_adr_src),
    .o_mem_read(b_mem_read), .o_mem_write(b_mem_write), .o_reg_write(b_reg_write),
    .o_result_src(b_result_src), .o_alu_src_a(b_alu_src_a), .o_alu_src_b(b_alu_src_b),
    .o_imm_src(b_imm_src), .o_alu_ctrl(b_alu), .o_illegal(b_illegal), .o_state(b_state)
  );

  typedef struct packed {
    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic [1:0] result_src, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       illegal;
  } ctl_t;

  int checks = 0;
  int errors = 0;
  int seq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit branch_ok(input bit full);
    return full ? !(f3 inside {3'b010, 3'b011}) : (f3 inside {3'b000, 3'b001});
  endfunction

  function automatic logic taken();
    case (f3)
      3'b000:  return zf;
      3'b001:  return !zf;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9.
  function automatic logic [3:0] alu_of(input bit rtype);
    case (f3)
      3'b000:  return (rtype && f75) ? 4'd1 : 4'd0;
      3'b001:  return 4'd7;
      3'b010:  return 4'd5;
      3'b011:  return 4'd6;
      3'b100:  return 4'd4;
      3'b101:  return f75 ? 4'd9 : 4'd8;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Control word the datapath expects in each phase of an instruction.
  function automatic ctl_t exp_ctl(input int st, input bit wait_en);
    ctl_t c = '0;
    bit rdy = ready || !wait_en;
    case (st)
      0:  begin c.mem_read = 1; c.b = 2; c.result_src = 2; c.ir_write = rdy; c.pc_write = rdy; end
      1:  begin c.a = 1; c.b = 1; c.imm = 3'b010; end
      2:  begin c.a = 2; c.b = 1; c.imm = op[5] ? 3'b001 : 3'b000; end
      3:  begin c.adr_src = 1; c.mem_read = 1; end
      4:  begin c.result_src = 1; c.reg_write = 1; end
      5:  begin c.adr_src = 1; c.mem_write = 1; end
      6:  begin c.a = 2; c.alu = alu_of(1'b1); end
      7:  begin c.a = 2; c.b = 1; c.alu = alu_of(1'b0); end
      8:  c.reg_write = 1;
      9:  begin c.a = 2; c.alu = 4'd1; c.pc_write = taken(); end
      10: begin c.a = 1; c.b = 2; c.pc_write = 1; end
      11: begin c.a = 2; c.b = 1; end
      12: begin c.a = op[5] ? 2'b11 : 2'b01; c.b = 1; c.imm = 3'b100; end
      13: c.illegal = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctl_t obs_ctl(input bit sel);
    if (sel)
      return {b_pc_write, b_ir_write, b_adr_src, b_mem_read, b_mem_write, b_reg_write,
              b_result_src, b_alu_src_a, b_alu_src_b, b_imm_src, b_alu[3:0], b_illegal};
    return {a_pc_write, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write,
            a_result_src, a_alu_src_a, a_alu_src_b, a_imm_src, a_alu, a_illegal};
  endfunction

  // Phase list of one instruction, derived from its class.
  task automatic build_seq(input bit full);
    seq.delete();
    seq.push_back(0);
    seq.push_back(1);
    case (op)
      7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
      7'b0100011: begin seq.push_back(2); seq.push_back(5); end
      7'b0110011: begin seq.push_back(6); seq.push_back(8); end
      7'b0010011: begin seq.push_back(7); seq.push_back(8); end
      7'b1100011: seq.push_back(branch_ok(full) ? 9 : 13);
      7'b1101111: begin seq.push_back(10); seq.push_back(8); end
      7'b1100111: begin seq.push_back(11); seq.push_back(10); seq.push_back(8); end
      7'b0110111, 7'b0010111: begin seq.push_back(12); seq.push_back(8); end
      default: seq.push_back(13);
    endcase
  endtask

  task automatic step_chk(input bit sel, input int st, input bit wait_en, input string tag);
    @(negedge clk);
    check({tag, "/state"}, sel ? b_state : a_state, st);
    check({tag, "/ctl"}, obs_ctl(sel), exp_ctl(st, wait_en));
    if (sel) check({tag, "/alu_hi"}, b_alu[4], 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input bit sel, input bit rnd, input int fw, input int mw, input string tag);
    bit wait_en = !sel;
    int waits;
    int st;
    build_seq(!sel);
    foreach (seq[i]) begin
      waits = 0;
      st = seq[i];
      forever begin
        if (rnd) begin
          zf = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
          ready = (waits >= 3) || ($urandom_range(0, 2) != 0);
        end else if (!wait_en) begin
          ready = 1'b0;
        end else begin
          ready = (st == 0) ? (waits >= fw) : (st == 3 || st == 5) ? (waits >= mw) : 1'b1;
        end
        step_chk(sel, st, wait_en, tag);
        if ((st == 0 || st == 3 || st == 5) && wait_en && !ready) waits++;
        else break;
      end
    end
  endtask

  task automatic rand_instr(input bit full);
    case ($urandom_range(0, 8))
      0: op = 7'b0000011;
      1: op = 7'b0100011;
      2: op = 7'b0110011;
      3: op = 7'b0010011;
      4: op = 7'b1100011;
      5: op = 7'b1101111;
      6: op = 7'b1100111;
      7: op = 7'b0110111;
      default: op = 7'b0010111;
    endcase
    f3  = 3'($urandom);
    f75 = 1'($urandom);
    if (op == 7'b1100011) while (!branch_ok(full)) f3 = 3'($urandom);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    op = '0; f3 = '0; f75 = 0; zf = 0; lt = 0; ltu = 0; ready = 1;
    rst_n_a = 0; rst_n_b = 0;
    repeat (2) @(posedge clk);
    #1;

    @(negedge clk);
    check("rst_a_state", a_state, 0);
    check("rst_a_ctl", obs_ctl(1'b0), 0);
    check("rst_b_ctl", obs_ctl(1'b1), 0);
    check("rst_b_alu_hi", b_alu[4], 0);
    @(posedge clk);
    #1;
    rst_n_a = 1;

    op = 7'b0110011; f3 = 3'b000; f75 = 1;
    run_instr(1'b0, 1'b0, 0, 0, "r_sub");
    op = 7'b0000011; f3 = 3'b010; f75 = 0;
    run_instr(1'b0, 1'b0, 0, 2, "load_wait");
    op = 7'b1100011; f3 = 3'b001; zf = 0;
    run_instr(1'b0, 1'b0, 0, 0, "bne_taken");
    zf = 1;
    run_instr(1'b0, 1'b0, 0, 0, "bne_not");
    f3 = 3'b100; lt = 1;
    run_instr(1'b0, 1'b0, 0, 0, "blt_taken");
    f3 = 3'b111; ltu = 1;
    run_instr(1'b0, 1'b0, 0, 0, "bgeu_not");
    op = 7'b1100111; f3 = 3'b000;
    run_instr(1'b0, 1'b0, 0, 0, "jalr");
    op = 7'b0110111;
    run_instr(1'b0, 1'b0, 0, 0, "lui");
    op = 7'b0010111;
    run_instr(1'b0, 1'b0, 1, 0, "auipc_fwait");
    op = 7'b0100011; f3 = 3'b010;
    run_instr(1'b0, 1'b0, 0, 1, "store_wait");

    repeat (80) begin
      rand_instr(1'b1);
      run_instr(1'b0, 1'b1, 0, 0, "rand");
    end

    op = 7'b0100011; f3 = 3'b010; ready = 1;
    step_chk(1'b0, 0, 1'b1, "st_rst_fetch");
    step_chk(1'b0, 1, 1'b1, "st_rst_decode");
    step_chk(1'b0, 2, 1'b1, "st_rst_memadr");
    ready = 0;
    @(negedge clk);
    check("st_rst_memwrite_state", a_state, 5);
    check("st_rst_memwrite_strobe", a_mem_write, 1);
    #2 rst_n_a = 0;
    #1;
    check("st_rst_mem_write_drop", a_mem_write, 0);
    check("st_rst_no_reg_write", a_reg_write, 0);
    check("st_rst_no_pc_write", a_pc_write, 0);
    check("st_rst_state", a_state, 0);
    check("st_rst_ctl", obs_ctl(1'b0), 0);
    @(posedge clk);
    #1;
    rst_n_a = 1;

    op = 7'b1111111;
    run_instr(1'b0, 1'b0, 0, 0, "illegal");
    repeat (10) step_chk(1'b0, 13, 1'b1, "trap_hold");
    @(negedge clk);
    #1 rst_n_a = 0;
    #1;
    check("trap_rst_illegal", a_illegal, 0);
    check("trap_rst_state", a_state, 0);
    @(posedge clk);
    #1;
    rst_n_a = 1;
    op = 7'b0110011; f3 = 3'b101; f75 = 1;
    run_instr(1'b0, 1'b0, 0, 0, "after_trap_sra");

    rst_n_b = 1;
    op = 7'b0110011; f3 = 3'b000; f75 = 1;
    run_instr(1'b1, 1'b0, 0, 0, "b_nowait_r");
    op = 7'b0000011; f3 = 3'b010; f75 = 0;
    run_instr(1'b1, 1'b0, 0, 0, "b_nowait_load");
    op = 7'b1100011; f3 = 3'b000; zf = 1;
    run_instr(1'b1, 1'b0, 0, 0, "b_beq");
    f3 = 3'b100;
    run_instr(1'b1, 1'b0, 0, 0, "b_blt_trap");
    repeat (3) step_chk(1'b1, 13, 1'b0, "b_trap_hold");
    rst_n_b = 0;
    #1;
    check("b_rst_illegal", b_illegal, 0);
    check("b_rst_state", b_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
